booth_mult_seq: RTL and testbench



---
 rtl/booth_mult_seq.sv | 143 ++++++++++++++
 tb/tb_booth_mult_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned operands selected per operation.
// Latency: accept at edge E0, out_valid high after edge E0+WIDTH+1; data-independent.
// Backpressure: one operation in flight; in_ready low in BUSY/DONE, p/out_valid held until out_ready.
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  // Counter must reach WIDTH+1 without wrapping.
  localparam int CNT_W = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  // Upper accumulator: one guard bit above the (WIDTH+1)-bit extended operand range
  // so add/subtract never overflows.
  logic [WIDTH+1:0]   acc_q, acc_d;
  // Extended multiplier; shifts right as product bits shift in from the accumulator.
  logic [WIDTH:0]     q_q, q_d;
  logic               qm1_q, qm1_d;
  // Extended multiplicand, held for the whole operation.
  logic [WIDTH:0]     mcand_q, mcand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;

  logic [WIDTH+1:0]   mcand_sx;
  logic [WIDTH+1:0]   sum;
  logic [WIDTH+1:0]   step_acc;
  logic [WIDTH:0]     step_q;
  logic               step_qm1;
  logic               last_step;
  logic [WIDTH:0]     a_ext;
  logic [WIDTH:0]     b_ext;

  // Operand extension to WIDTH+1 bits: sign bit copied only in signed mode, so unsigned
  // operands become non-negative signed numbers and one Booth datapath serves both modes.
  always_comb begin
    a_ext = {is_signed & a[WIDTH-1], a};
    b_ext = {is_signed & b[WIDTH-1], b};
  end

  // One Booth step: add/subtract multiplicand per (q0, q-1), then arithmetic shift right.
  always_comb begin
    mcand_sx = {mcand_q[WIDTH], mcand_q};
    case ({q_q[0], qm1_q})
      2'b01:   sum = acc_q + mcand_sx;
      2'b10:   sum = acc_q - mcand_sx;
      default: sum = acc_q;
    endcase
    step_acc  = {sum[WIDTH+1], sum[WIDTH+1:1]};
    step_q    = {sum[0], q_q[WIDTH:1]};
    step_qm1  = q_q[0];
    last_step = (cnt_q == CNT_W'(WIDTH));
  end

  // Next-state and datapath control; everything holds unless the current state says otherwise.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d = a_ext;
          q_d     = b_ext;
          acc_d   = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        acc_d = step_acc;
        q_d   = step_q;
        qm1_d = step_qm1;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_step) begin
          // The exact product always fits in the low 2*WIDTH bits of {acc, q},
          // including the signed (-2^(WIDTH-1))^2 corner.
          p_d     = {step_acc[WIDTH-2:0], step_q};
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      mcand_q <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  // Handshake outputs decode directly from the state register.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q == S_BUSY);
    out_valid = (state_q == S_DONE);
    p         = p_q;
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: WIDTH=8 directed vectors plus a WIDTH=4 exhaustive sweep.
// Inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
// Every wait on the DUT is bounded; a timeout counts as a failed comparison.
module tb_booth_mult_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, is_signed, out_valid, out_ready, busy;
  logic [7:0]  a, b;
  logic [15:0] p;

  logic        v4_in_valid, v4_in_ready, v4_is_signed, v4_out_valid, v4_out_ready, v4_busy;
  logic [3:0]  v4_a, v4_b;
  logic [7:0]  v4_p;

  int passed;
  int total;

  booth_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
    .out_ready(out_ready), .p(p), .busy(busy)
  );

  booth_mult_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4_in_valid), .in_ready(v4_in_ready),
    .a(v4_a), .b(v4_b), .is_signed(v4_is_signed), .out_valid(v4_out_valid),
    .out_ready(v4_out_ready), .p(v4_p), .busy(v4_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one WIDTH=8 operation and wait for out_valid; lat = edges from accept to out_valid.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic ts, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 40) begin tick(); w++; end
    a = ta; b = tb; is_signed = ts; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    total++;
    if (!out_valid) $display("FAIL op8_timeout a=%h b=%h got out_valid=0 want 1", ta, tb);
    else passed++;
  endtask

  task automatic handshake8();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    total++; if (p !== 16'h0000) $display("FAIL reset_p got %h want 0000", p); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL idle_after_reset got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    else passed++;
  endtask

  task automatic test_extreme_signed();
    int lat;
    op8(8'h80, 8'h80, 1'b1, lat);
    total++; if (lat != 9) $display("FAIL extreme_latency got %0d want 9", lat); else passed++;
    total++; if (p !== 16'h4000) $display("FAIL extreme_p got %h want 4000", p); else passed++;
    total++; if (in_ready !== 1'b0 || busy !== 1'b0)
      $display("FAIL done_flags got in_ready=%b busy=%b want 0/0", in_ready, busy);
    else passed++;
    handshake8();
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL after_handshake got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    else passed++;
  endtask

  task automatic test_sign_modes();
    int lat;
    op8(8'hFF, 8'hFF, 1'b1, lat);
    total++; if (p !== 16'h0001) $display("FAIL ff_ff_signed got %h want 0001", p); else passed++;
    handshake8();
    op8(8'hFF, 8'hFF, 1'b0, lat);
    total++; if (p !== 16'hFE01) $display("FAIL ff_ff_unsigned got %h want FE01", p); else passed++;
    handshake8();
    // is_signed flipped right after accept must not affect the result.
    a = 8'hFF; b = 8'hFF; is_signed = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; is_signed = 1'b1; a = 8'h00; b = 8'h00;
    total++; if (busy !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL busy_flags got busy=%b in_ready=%b want 1/0", busy, in_ready);
    else passed++;
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    total++; if (p !== 16'hFE01 || lat != 9)
      $display("FAIL sign_sampled_at_accept got p=%h lat=%0d want FE01/9", p, lat);
    else passed++;
    is_signed = 1'b0;
    handshake8();
  endtask

  task automatic test_mixed_signs();
    int lat;
    op8(8'hFF, 8'h7F, 1'b1, lat);
    total++; if (p !== 16'hFF81) $display("FAIL neg1_x_127 got %h want FF81", p); else passed++;
    handshake8();
    op8(8'h05, 8'hFD, 1'b1, lat);
    total++; if (p !== 16'hFFF1) $display("FAIL 5_x_neg3 got %h want FFF1", p); else passed++;
    handshake8();
    op8(8'h7F, 8'h80, 1'b1, lat);
    total++; if (p !== 16'hC080) $display("FAIL 127_x_neg128 got %h want C080", p); else passed++;
    handshake8();
  endtask

  task automatic test_zero();
    int lat;
    op8(8'h00, 8'h5A, 1'b0, lat);
    total++; if (p !== 16'h0000 || lat != 9)
      $display("FAIL zero_operand got p=%h lat=%0d want 0000/9", p, lat);
    else passed++;
    handshake8();
  endtask

  task automatic test_backpressure();
    int lat;
    logic stable;
    op8(8'h12, 8'h34, 1'b0, lat);
    total++; if (p !== 16'h03A8) $display("FAIL bp_product got %h want 03A8", p); else passed++;
    a = 8'h0A; b = 8'h0B; is_signed = 1'b0; in_valid = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (p !== 16'h03A8 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) stable = 1'b0;
    end
    total++; if (!stable) $display("FAIL bp_hold got unstable p/out_valid/in_ready want held"); else passed++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    else passed++;
    tick();
    in_valid = 1'b0;
    total++; if (busy !== 1'b1) $display("FAIL bp_next_accept got busy=%b want 1", busy); else passed++;
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    total++; if (p !== 16'h006E || lat != 9)
      $display("FAIL bp_next_op got p=%h lat=%0d want 006E/9", p, lat);
    else passed++;
    handshake8();
  endtask

  task automatic test_back_to_back();
    int lat;
    op8(8'h0A, 8'h0B, 1'b0, lat);
    a = 8'h10; b = 8'h10; is_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL b2b_idle_cycle got in_ready=%b busy=%b want 1/0", in_ready, busy);
    else passed++;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    total++; if (p !== 16'h0100 || lat != 9)
      $display("FAIL b2b_second got p=%h lat=%0d want 0100/9", p, lat);
    else passed++;
    handshake8();
  endtask

  task automatic test_reset_midop();
    int lat;
    logic saw_valid;
    a = 8'h7F; b = 8'h7F; is_signed = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || p !== 16'h0000)
      $display("FAIL midop_reset got in_ready=%b busy=%b out_valid=%b p=%h want 1/0/0/0000",
               in_ready, busy, out_valid, p);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) saw_valid = 1'b1;
    end
    total++; if (saw_valid) $display("FAIL midop_no_valid got out_valid pulse want none"); else passed++;
    op8(8'h03, 8'h04, 1'b0, lat);
    total++; if (p !== 16'h000C || lat != 9)
      $display("FAIL midop_next got p=%h lat=%0d want 000C/9", p, lat);
    else passed++;
    handshake8();
  endtask

  task automatic test_exhaustive_w4();
    logic [3:0] ta, tb;
    logic [7:0] exp;
    int xa, xb, lat;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j < 16; j++) begin
          ta = i[3:0]; tb = j[3:0];
          xa = (m == 1) ? int'($signed(ta)) : int'(ta);
          xb = (m == 1) ? int'($signed(tb)) : int'(tb);
          exp = 8'(xa * xb);
          v4_a = ta; v4_b = tb; v4_is_signed = (m == 1); v4_in_valid = 1'b1;
          tick();
          v4_in_valid = 1'b0;
          lat = 0;
          while (!v4_out_valid && lat < 20) begin tick(); lat++; end
          total++;
          if (v4_p !== exp || lat != 5)
            $display("FAIL w4_sweep s=%0d a=%h b=%h got p=%h lat=%0d want %h/5", m, ta, tb, v4_p, lat, exp);
          else passed++;
          v4_out_ready = 1'b1;
          tick();
          v4_out_ready = 1'b0;
        end
      end
    end
  endtask

  initial begin
    passed = 0; total = 0;
    in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0; out_ready = 1'b0;
    v4_in_valid = 1'b0; v4_a = '0; v4_b = '0; v4_is_signed = 1'b0; v4_out_ready = 1'b0;
    test_reset();
    test_extreme_signed();
    test_sign_modes();
    test_mixed_signs();
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    test_exhaustive_w4();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
